// File: rtl/riscv_bpu_pkg.sv
// Shared types for the branch prediction unit: 2-bit counter encoding and
// the counter values used at reset and on allocation.
package riscv_bpu_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/riscv_bpu_ctr.sv
// 2-bit saturating counter next-state logic used on the BTB update path.
module riscv_bpu_ctr
  import riscv_bpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  ctr_e cur;
  assign cur = ctr_e'(ctr_i);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (cur != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (cur != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_bpu.sv
// Direct-mapped BTB with 2-bit counters: same-cycle fetch prediction and
// combinational execute-stage mispredict/redirect.
module riscv_bpu
  import riscv_bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 12
) (
  input  logic        i_riscv_bpu_clk,
  input  logic        i_riscv_bpu_rst,
  input  logic [63:0] i_riscv_bpu_if_pc,
  output logic        o_riscv_bpu_pred_taken,
  output logic [63:0] o_riscv_bpu_pred_target,
  input  logic        i_riscv_bpu_ex_valid,
  input  logic [63:0] i_riscv_bpu_ex_pc,
  input  logic        i_riscv_bpu_ex_taken,
  input  logic [63:0] i_riscv_bpu_ex_target,
  input  logic        i_riscv_bpu_ex_compressed,
  input  logic        i_riscv_bpu_ex_pred_taken,
  input  logic [63:0] i_riscv_bpu_ex_pred_target,
  output logic        o_riscv_bpu_mispredict,
  output logic [63:0] o_riscv_bpu_redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_HI = TAG_W + IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [63:0]        target_q [ENTRIES];
  logic [63:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, pred_taken;
  logic [1:0]       ctr_next;
  logic             mispredict;
  logic [63:0]      fallthrough_pc;
  logic             unused_pc_bits;

  // Index skips bit 0: compressed instructions make every halfword a branch site.
  assign if_idx = i_riscv_bpu_if_pc[IDX_W:1];
  assign if_tag = i_riscv_bpu_if_pc[TAG_HI:IDX_W+1];
  assign ex_idx = i_riscv_bpu_ex_pc[IDX_W:1];
  assign ex_tag = i_riscv_bpu_ex_pc[TAG_HI:IDX_W+1];
  assign unused_pc_bits = ^{i_riscv_bpu_if_pc[63:TAG_HI+1], i_riscv_bpu_if_pc[0]};

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  riscv_bpu_ctr u_ctr (
    .ctr_i   (ctr_q[ex_idx]),
    .taken_i (i_riscv_bpu_ex_taken),
    .ctr_o   (ctr_next)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (i_riscv_bpu_ex_valid) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ctr_next;
        if (i_riscv_bpu_ex_taken) target_d[ex_idx] = i_riscv_bpu_ex_target;
      end else if (i_riscv_bpu_ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = i_riscv_bpu_ex_target;
        ctr_d[ex_idx]    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge i_riscv_bpu_clk or posedge i_riscv_bpu_rst) begin
    if (i_riscv_bpu_rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the EX inputs.
  assign pred_taken = !i_riscv_bpu_rst && if_hit && ctr_q[if_idx][1];
  assign o_riscv_bpu_pred_taken  = pred_taken;
  assign o_riscv_bpu_pred_target = pred_taken ? target_q[if_idx] : 64'd0;

  assign mispredict = !i_riscv_bpu_rst && i_riscv_bpu_ex_valid &&
                      ((i_riscv_bpu_ex_pred_taken != i_riscv_bpu_ex_taken) ||
                       (i_riscv_bpu_ex_taken &&
                        (i_riscv_bpu_ex_pred_target != i_riscv_bpu_ex_target)));

  assign fallthrough_pc = i_riscv_bpu_ex_pc +
                          (i_riscv_bpu_ex_compressed ? 64'd2 : 64'd4);

  assign o_riscv_bpu_mispredict  = mispredict;
  assign o_riscv_bpu_redirect_pc = !mispredict ? 64'd0 :
                                   (i_riscv_bpu_ex_taken ? i_riscv_bpu_ex_target
                                                         : fallthrough_pc);

endmodule

// File: tb/tb_riscv_bpu.sv
// Directed self-checking bench for riscv_bpu (ENTRIES=64, TAG_W=12):
// index = pc[6:1], tag = pc[18:7].
module tb_riscv_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        ex_compressed;
  logic        ex_pred_taken;
  logic [63:0] ex_pred_target;
  logic        mispredict;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        tk;
    logic        ptk;
    logic [63:0] ptgt;
    logic        cmp;
    logic        exp_m;
    logic [63:0] exp_r;
    logic        exp_p;
    logic [63:0] exp_t;
  } step_t;

  // Entry at 0x100 starts at WT/target 0x180; taken updates use target 0x1C0.
  step_t steps [9] = '{
    '{1'b0, 1'b1, 64'h180, 1'b1, 1'b1, 64'h102, 1'b0, 64'h0},
    '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b0, 64'h0},
    '{1'b0, 1'b1, 64'h180, 1'b0, 1'b1, 64'h104, 1'b0, 64'h0},
    '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h1C0, 1'b0, 64'h0},
    '{1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 64'h1C0, 1'b1, 64'h1C0},
    '{1'b1, 1'b1, 64'h1C0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h1C0},
    '{1'b1, 1'b1, 64'h180, 1'b0, 1'b1, 64'h1C0, 1'b1, 64'h1C0},
    '{1'b0, 1'b1, 64'h1C0, 1'b0, 1'b1, 64'h104, 1'b1, 64'h1C0},
    '{1'b0, 1'b1, 64'h1C0, 1'b1, 1'b1, 64'h102, 1'b0, 64'h0}
  };

  riscv_bpu dut (
    .i_riscv_bpu_clk            (clk),
    .i_riscv_bpu_rst            (rst),
    .i_riscv_bpu_if_pc          (if_pc),
    .o_riscv_bpu_pred_taken     (pred_taken),
    .o_riscv_bpu_pred_target    (pred_target),
    .i_riscv_bpu_ex_valid       (ex_valid),
    .i_riscv_bpu_ex_pc          (ex_pc),
    .i_riscv_bpu_ex_taken       (ex_taken),
    .i_riscv_bpu_ex_target      (ex_target),
    .i_riscv_bpu_ex_compressed  (ex_compressed),
    .i_riscv_bpu_ex_pred_taken  (ex_pred_taken),
    .i_riscv_bpu_ex_pred_target (ex_pred_target),
    .o_riscv_bpu_mispredict     (mispredict),
    .o_riscv_bpu_redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_ex(input logic v, input logic [63:0] pc, input logic tk,
                        input logic [63:0] tgt, input logic cmp,
                        input logic ptk, input logic [63:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_compressed = cmp; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic set_idle();
    set_ex(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_pc = 64'h8000_0000;
    set_ex(1'b1, 64'h100, 1'b1, 64'h180, 1'b0, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL reset_misp_held: got %b expected 0", mispredict); end
    checks++; if (redirect_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_redir_held: got %h expected 0", redirect_pc); end
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 64'h0) begin errors++; $display("[TB] FAIL reset_pred_target: got %h expected 0", pred_target); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL reset_misp: got %b expected 0", mispredict); end
    checks++; if (redirect_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_redir: got %h expected 0", redirect_pc); end
  endtask

  task automatic test_alloc();
    @(negedge clk);
    if_pc = 64'h100;
    set_ex(1'b1, 64'h100, 1'b1, 64'h180, 1'b0, 1'b0, 64'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL alloc_misp: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 64'h180) begin errors++; $display("[TB] FAIL alloc_redir: got %h expected 180", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alloc_pre_pred: got %b expected 0", pred_taken); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alloc_pred_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 64'h180) begin errors++; $display("[TB] FAIL alloc_pred_target: got %h expected 180", pred_target); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL alloc_idle_misp: got %b expected 0", mispredict); end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if_pc = 64'h100;
      set_ex(1'b1, 64'h100, steps[i].tk, 64'h1C0, steps[i].cmp, steps[i].ptk, steps[i].ptgt);
      #1;
      checks++; if (mispredict !== steps[i].exp_m) begin errors++; $display("[TB] FAIL ctr_misp[%0d]: got %b expected %b", i, mispredict, steps[i].exp_m); end
      checks++; if (redirect_pc !== steps[i].exp_r) begin errors++; $display("[TB] FAIL ctr_redir[%0d]: got %h expected %h", i, redirect_pc, steps[i].exp_r); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (pred_taken !== steps[i].exp_p) begin errors++; $display("[TB] FAIL ctr_pred[%0d]: got %b expected %b", i, pred_taken, steps[i].exp_p); end
      checks++; if (pred_target !== steps[i].exp_t) begin errors++; $display("[TB] FAIL ctr_target[%0d]: got %h expected %h", i, pred_target, steps[i].exp_t); end
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    set_ex(1'b1, 64'h100, 1'b1, 64'h140, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    if_pc = 64'h100;
    #1;
    checks++; if (pred_target !== 64'h140) begin errors++; $display("[TB] FAIL alias_first_target: got %h expected 140", pred_target); end
    @(negedge clk);
    set_ex(1'b1, 64'h180, 1'b1, 64'h300, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    if_pc = 64'h100;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_old_miss: got %b expected 0", pred_taken); end
    if_pc = 64'h180;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_new_hit: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 64'h300) begin errors++; $display("[TB] FAIL alias_new_target: got %h expected 300", pred_target); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    if_pc = 64'h200;
    set_ex(1'b1, 64'h200, 1'b1, 64'h280, 1'b0, 1'b0, 64'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_pred: got %b expected 0", pred_taken); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_next_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 64'h280) begin errors++; $display("[TB] FAIL same_cycle_next_target: got %h expected 280", pred_target); end
  endtask

  task automatic test_idle_no_change();
    @(negedge clk);
    set_ex(1'b0, 64'h200, 1'b0, 64'h0, 1'b0, 1'b1, 64'h280);
    if_pc = 64'h200;
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL idle_misp: got %b expected 0", mispredict); end
    checks++; if (redirect_pc !== 64'h0) begin errors++; $display("[TB] FAIL idle_redir: got %h expected 0", redirect_pc); end
    @(negedge clk);
    set_ex(1'b0, 64'h400, 1'b1, 64'hDEAD, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_ex(1'b0, 64'h200, 1'b1, 64'hBEEF, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL idle_keep_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 64'h280) begin errors++; $display("[TB] FAIL idle_keep_target: got %h expected 280", pred_target); end
    if_pc = 64'h400;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_alloc: got %b expected 0", pred_taken); end
  endtask

  task automatic test_back_to_back();
    // 0x200 is at WT: NT, NT, T in consecutive cycles lands on WNT.
    @(negedge clk);
    if_pc = 64'h200;
    set_ex(1'b1, 64'h200, 1'b0, 64'h0, 1'b0, 1'b1, 64'h280);
    #1;
    checks++; if (redirect_pc !== 64'h204) begin errors++; $display("[TB] FAIL b2b_redir0: got %h expected 204", redirect_pc); end
    @(negedge clk);
    set_ex(1'b1, 64'h200, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pred1: got %b expected 0", pred_taken); end
    @(negedge clk);
    set_ex(1'b1, 64'h200, 1'b1, 64'h280, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_pred: got %b expected 0", pred_taken); end
  endtask

  task automatic test_redirect_wrap();
    @(negedge clk);
    set_ex(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 1'b0, 1'b1, 64'h10);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL wrap_misp: got %b expected 1", mispredict); end
    checks++; if (redirect_pc !== 64'h2) begin errors++; $display("[TB] FAIL wrap_redir4: got %h expected 2", redirect_pc); end
    ex_compressed = 1'b1;
    #1;
    checks++; if (redirect_pc !== 64'h0) begin errors++; $display("[TB] FAIL wrap_redir2: got %h expected 0", redirect_pc); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_ex(1'b1, 64'h00A, 1'b1, 64'h50, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    if_pc = 64'h00A;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL mid_alloc_pred: got %b expected 1", pred_taken); end
    set_ex(1'b1, 64'h00A, 1'b0, 64'h0, 1'b0, 1'b1, 64'h50);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_pred: got %b expected 0", pred_taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_misp: got %b expected 0", mispredict); end
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL mid_post_pred_a: got %b expected 0", pred_taken); end
    if_pc = 64'h200;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL mid_post_pred_b: got %b expected 0", pred_taken); end
    @(negedge clk);
    set_ex(1'b1, 64'h00A, 1'b1, 64'h60, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    set_idle();
    if_pc = 64'h00A;
    #1;
    checks++; if (pred_target !== 64'h60) begin errors++; $display("[TB] FAIL mid_realloc_target: got %h expected 60", pred_target); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_idle_no_change();
    test_back_to_back();
    test_redirect_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
